// File: rtl/axis_spike_decoder.sv
// Receive-side spike decoder: rebuilds per-time-step spike bitmaps from AXI-stream
// {block, neuron} event beats, double-buffered between accumulation and presentation.
module axis_spike_decoder #(
   parameter int T  = 4,
   parameter int N  = 8,
   parameter int TA = (T > 1) ? $clog2(T) : 1,
   parameter int NA = (N > 1) ? $clog2(N) : 1,
   parameter int CW = 16
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                s_tvalid,
   output logic                s_tready,
   input  logic [TA+NA-1:0]    s_tdata,
   input  logic                s_tuser,
   input  logic                s_tlast,
   output logic [T*N-1:0]      spike_out,
   output logic                spike_valid,
   input  logic                spike_ready,
   output logic [CW-1:0]       frame_count,
   output logic                err_range,
   input  logic                err_clr
);

   localparam int IW = (T * N > 1) ? $clog2(T * N) : 1;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [T*N-1:0]   acc_r, acc_s, beat_acc_s;
   logic [CW-1:0]    cnt_r, cnt_s, beat_cnt_s;
   logic [T*N-1:0]   out_r, out_s;
   logic [CW-1:0]    fc_r, fc_s;
   logic             valid_r, valid_s;
   logic             tready_r;
   logic             err_r, err_s;

   logic [TA-1:0]    blk_s;
   logic [NA-1:0]    nrn_s;
   logic [IW-1:0]    bit_idx_s;
   logic             in_range_s;
   logic             accept_s;
   logic             hit_s;
   logic             new_bit_s;
   logic             release_s;
   logic             read_free_s;

   assign blk_s       = s_tdata[TA+NA-1:NA];
   assign nrn_s       = s_tdata[NA-1:0];
   assign in_range_s  = (int'(blk_s) < T) && (int'(nrn_s) < N);
   assign bit_idx_s   = IW'(int'(blk_s) * N + int'(nrn_s));
   assign accept_s    = s_tvalid && (state_r == ACCUM);
   assign hit_s       = accept_s && !s_tuser && in_range_s;
   assign release_s   = valid_r && spike_ready;
   assign read_free_s = !valid_r || spike_ready;

   assign s_tready    = tready_r;
   assign spike_out   = out_r;
   assign spike_valid = valid_r;
   assign frame_count = fc_r;
   assign err_range   = err_r;

   // Write-bank image and counter as they would look after the current beat.
   always_comb begin
      beat_acc_s = acc_r;
      beat_cnt_s = cnt_r;
      new_bit_s  = 1'b0;
      if (hit_s) begin
         new_bit_s             = !acc_r[bit_idx_s];
         beat_acc_s[bit_idx_s] = 1'b1;
      end else begin
         new_bit_s = 1'b0;
      end
      if (new_bit_s && (cnt_r != {CW{1'b1}})) begin
         beat_cnt_s = cnt_r + CW'(1'b1);
      end else begin
         beat_cnt_s = cnt_r;
      end
   end

   // Next-state and bank-swap decisions; a swap copies the sealed bank into the read bank.
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      cnt_s   = cnt_r;
      out_s   = out_r;
      fc_s    = fc_r;
      valid_s = valid_r;
      case (state_r)
         ACCUM: begin
            if (release_s) begin
               valid_s = 1'b0;
            end else begin
               valid_s = valid_r;
            end
            if (accept_s) begin
               if (s_tlast && read_free_s) begin
                  out_s   = beat_acc_s;
                  fc_s    = beat_cnt_s;
                  valid_s = 1'b1;
                  acc_s   = {(T*N){1'b0}};
                  cnt_s   = {CW{1'b0}};
               end else if (s_tlast) begin
                  acc_s   = beat_acc_s;
                  cnt_s   = beat_cnt_s;
                  state_s = HOLD;
               end else begin
                  acc_s = beat_acc_s;
                  cnt_s = beat_cnt_s;
               end
            end else begin
               acc_s = acc_r;
               cnt_s = cnt_r;
            end
         end
         HOLD: begin
            if (release_s) begin
               out_s   = acc_r;
               fc_s    = cnt_r;
               valid_s = 1'b1;
               acc_s   = {(T*N){1'b0}};
               cnt_s   = {CW{1'b0}};
               state_s = ACCUM;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = ACCUM;
         end
      endcase
   end

   // Sticky range error; a new error in the same cycle as a clear wins.
   always_comb begin
      if (accept_s && !s_tuser && !in_range_s) begin
         err_s = 1'b1;
      end else if (err_clr) begin
         err_s = 1'b0;
      end else begin
         err_s = err_r;
      end
   end

   // FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r <= ACCUM;
      end else begin
         state_r <= state_s;
      end
   end

   // Bank, output and error registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc_r    <= {(T*N){1'b0}};
         cnt_r    <= {CW{1'b0}};
         out_r    <= {(T*N){1'b0}};
         fc_r     <= {CW{1'b0}};
         valid_r  <= 1'b0;
         tready_r <= 1'b1;
         err_r    <= 1'b0;
      end else begin
         acc_r    <= acc_s;
         cnt_r    <= cnt_s;
         out_r    <= out_s;
         fc_r     <= fc_s;
         valid_r  <= valid_s;
         tready_r <= (state_s == ACCUM);
         err_r    <= err_s;
      end
   end

endmodule

// File: tb/tb_axis_spike_decoder.sv
// Scoreboard bench for axis_spike_decoder: directed scenarios plus random frames,
// checked against a set-of-spikes reference model.
module tb_axis_spike_decoder;

   localparam int T  = 4;
   localparam int N  = 8;
   localparam int TA = 3;
   localparam int NA = 3;
   localparam int CW = 16;

   logic              aclk;
   logic              aresetn;
   logic              s_tvalid;
   logic              s_tready;
   logic [TA+NA-1:0]  s_tdata;
   logic              s_tuser;
   logic              s_tlast;
   logic [T*N-1:0]    spike_out;
   logic              spike_valid;
   logic              spike_ready;
   logic [CW-1:0]     frame_count;
   logic              err_range;
   logic              err_clr;

   int                tests = 0;
   int                fails = 0;
   int                stall_cnt = 0;
   bit                rnd_ready = 1'b0;
   logic [T*N-1:0]    cur_map = '0;
   logic [T*N-1:0]    exp_q[$];

   axis_spike_decoder #(.T(T), .N(N), .TA(TA), .NA(NA), .CW(CW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tuser(s_tuser), .s_tlast(s_tlast),
      .spike_out(spike_out), .spike_valid(spike_valid), .spike_ready(spike_ready),
      .frame_count(frame_count), .err_range(err_range), .err_clr(err_clr)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one beat, wait (bounded) for acceptance, then update the reference model.
   task automatic send_beat(input int blk, input int nrn, input bit user, input bit last);
      int  waited;
      bit  accepted;
      waited   = 0;
      accepted = 1'b0;
      s_tdata  = {3'(blk), 3'(nrn)};
      s_tuser  = user;
      s_tlast  = last;
      s_tvalid = 1'b1;
      while (!accepted && waited < 1000) begin
         @(negedge aclk);
         if (s_tready) begin
            @(posedge aclk);
            accepted = 1'b1;
         end else begin
            waited++;
         end
      end
      stall_cnt += waited;
      #1;
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
      tests++;
      if (!accepted) begin
         fails++;
         $display("FAIL beat_accept: beat (%0d,%0d) not accepted after %0d cycles, expected acceptance", blk, nrn, waited);
      end else begin
         if (!user && blk < T && nrn < N) cur_map[blk*N + nrn] = 1'b1;
         if (last) begin
            exp_q.push_back(cur_map);
            cur_map = '0;
         end
      end
   endtask

   // Let the consumer take everything outstanding; bounded.
   task automatic wait_idle();
      int n;
      n = 0;
      spike_ready = 1'b1;
      while ((spike_valid || exp_q.size() != 0) && n < 200) begin
         @(posedge aclk);
         #1;
         n++;
      end
      tests++;
      if (spike_valid || exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d frames still expected, spike_valid=%0b, expected 0 and 0", exp_q.size(), spike_valid);
      end
   endtask

   // Monitor: every frame handed over (valid & ready) must match the next expected frame.
   always @(negedge aclk) begin
      if (aresetn && spike_valid && spike_ready) begin
         logic [T*N-1:0] e;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL frame_unexpected: got spike_out=%0h frame_count=%0d, expected no frame", spike_out, frame_count);
         end else begin
            e = exp_q.pop_front();
            if (spike_out !== e || frame_count !== CW'($countones(e))) begin
               fails++;
               $display("FAIL frame: got spike_out=%0h frame_count=%0d, expected spike_out=%0h frame_count=%0d",
                        spike_out, frame_count, e, $countones(e));
            end
         end
      end
   end

   // Random consumer backpressure during the random phase.
   initial begin
      forever begin
         @(posedge aclk);
         #2;
         if (rnd_ready) spike_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
      spike_ready = 1'b0; err_clr = 1'b0;
      #32;
      chk("rst_tready", s_tready, 1);
      chk("rst_valid", spike_valid, 0);
      chk("rst_out", spike_out, 0);
      chk("rst_count", frame_count, 0);
      chk("rst_err", err_range, 0);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      spike_ready = 1'b1;

      // Three distinct spikes, latency of one cycle after tlast.
      send_beat(0, 3, 0, 0);
      send_beat(2, 5, 0, 0);
      send_beat(3, 7, 0, 1);
      chk("lat_valid", spike_valid, 1);
      chk("t1_out", spike_out, 64'h8020_0008);
      chk("t1_count", frame_count, 3);
      wait_idle();

      // Duplicates counted once.
      send_beat(1, 2, 0, 0);
      send_beat(1, 2, 0, 0);
      send_beat(1, 2, 0, 1);
      chk("dup_out", spike_out, 64'h400);
      chk("dup_count", frame_count, 1);
      wait_idle();

      // Empty step.
      send_beat(0, 0, 1, 1);
      chk("empty_valid", spike_valid, 1);
      chk("empty_out", spike_out, 0);
      chk("empty_count", frame_count, 0);
      wait_idle();

      // Back-to-back single-beat steps with the consumer always ready.
      stall_cnt = 0;
      for (int k = 0; k < 6; k++) send_beat(k % T, (k * 3) % N, 0, 1);
      chk("b2b_stalls", stall_cnt, 0);
      wait_idle();

      // Backpressure: second frame is held while the first is unconsumed.
      spike_ready = 1'b0;
      send_beat(0, 0, 0, 1);
      chk("hold_a_out", spike_out, 64'h1);
      send_beat(1, 1, 0, 1);
      chk("hold_tready", s_tready, 0);
      chk("hold_keep_out", spike_out, 64'h1);
      @(posedge aclk); #1;
      chk("hold_tready2", s_tready, 0);
      chk("hold_keep_out2", spike_out, 64'h1);
      spike_ready = 1'b1;
      @(posedge aclk); #1;
      spike_ready = 1'b0;
      chk("hold_b_out", spike_out, 64'h200);
      chk("hold_b_valid", spike_valid, 1);
      chk("hold_b_tready", s_tready, 1);
      wait_idle();

      // Range error: sticky, cleared by err_clr, set wins over clear.
      send_beat(5, 0, 0, 1);
      chk("err_set", err_range, 1);
      wait_idle();
      err_clr = 1'b1;
      @(posedge aclk); #1;
      err_clr = 1'b0;
      chk("err_clr", err_range, 0);
      err_clr = 1'b1;
      send_beat(6, 3, 0, 1);
      err_clr = 1'b0;
      chk("err_set_wins", err_range, 1);
      wait_idle();
      err_clr = 1'b1;
      @(posedge aclk); #1;
      err_clr = 1'b0;
      chk("err_clr2", err_range, 0);

      // Reset in the middle of an unterminated frame.
      send_beat(1, 1, 0, 0);
      send_beat(3, 3, 0, 0);
      aresetn = 1'b0;
      cur_map = '0;
      exp_q.delete();
      #1;
      chk("mid_rst_valid", spike_valid, 0);
      chk("mid_rst_out", spike_out, 0);
      chk("mid_rst_tready", s_tready, 1);
      @(posedge aclk); @(posedge aclk); #3;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      send_beat(2, 0, 0, 1);
      chk("post_rst_out", spike_out, 64'h0001_0000);
      chk("post_rst_count", frame_count, 1);
      wait_idle();

      // Random frames under random backpressure.
      rnd_ready = 1'b1;
      for (int f = 0; f < 60; f++) begin
         int nb;
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            send_beat($urandom_range(0, T), $urandom_range(0, N - 1),
                      ($urandom_range(0, 9) == 0), (b == nb - 1));
         end
      end
      rnd_ready = 1'b0;
      #3;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
